l1_miss_arbiter: RTL and testbench
==================================

// Module: l1_miss_arbiter
// PURPOSE
//  Shares a single shared-cache request port between the L1 I- and D-cache miss ports of all
//  cores in a cluster. Round-robin arbitration; one registered output request stage; a
//  source-ID tracker FIFO so in-order responses route back to the issuing requester.
//  Sits between the per-core L1 caches and the cluster L2 cache manager.
// PARAMETERS
//  NUM_CORES       4   cores; NUM_REQ = 2*NUM_CORES (req 2i = I$ core i, 2i+1 = D$ core i)
//  ADDR_W          32  request address width
//  DATA_W          32  read/write data width
//  MAX_OUTSTANDING 4   tracker depth (power of 2, >=2); SRC_W = $clog2(NUM_REQ)
// PORTS
//  clk_i          in   1               clock
//  rst_ni         in   1               async active-low reset
//  req_valid_i    in   NUM_REQ         requester has a miss request
//  req_ready_o    out  NUM_REQ         request accepted this cycle (one-hot or zero)
//  req_addr_i     in   NUM_REQ*ADDR_W  packed addresses, slice r = [r*ADDR_W +: ADDR_W]
//  req_write_i    in   NUM_REQ         1 = write, 0 = read
//  req_wdata_i    in   NUM_REQ*DATA_W  packed write data
//  rsp_valid_o    out  NUM_REQ         response for requester r (one-hot or zero)
//  rsp_data_o     out  DATA_W          response data, shared by all requesters
//  m_req_valid_o  out  1               downstream request valid
//  m_req_ready_i  in   1               downstream accepts request
//  m_req_addr_o   out  ADDR_W          downstream address
//  m_req_write_o  out  1               downstream write flag
//  m_req_wdata_o  out  DATA_W          downstream write data
//  m_req_src_o    out  SRC_W           index of the granted requester
//  m_rsp_valid_i  in   1               downstream response valid (in issue order)
//  m_rsp_data_i   in   DATA_W          downstream response data
//  outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  tracker occupancy
//  rsp_err_o      out  1               sticky: response arrived with tracker empty
// BEHAVIOUR
//  Reset: all outputs 0; RR pointer = 0; tracker empty; slot empty.
//  load = (!m_req_valid_o || m_req_ready_i) && (outstanding_o < MAX_OUTSTANDING || m_rsp_valid_i).
//  Arbitration: when load and any req_valid_i, grant g = first valid index at or after RR
//   pointer, wrapping modulo NUM_REQ. req_ready_o[g] = 1 (combinational, same cycle).
//   At the clock edge: latch addr/write/wdata/src into slot; m_req_valid_o = 1; push g to tracker;
//   RR pointer = (g+1) mod NUM_REQ. The pointer holds when no grant is made.
//  Latency: req handshake at edge N -> m_req_valid_o high from cycle N+1.
//  Output slot: stable while m_req_valid_o && !m_req_ready_i. Handshake with no new grant -> valid=0.
//   Back-to-back issue: a handshake and a new grant in the same cycle reload the slot with no bubble.
//  Tracker: FIFO of SRC_W entries. Push on grant, pop on m_rsp_valid_i (not empty).
//   Simultaneous push and pop when full is allowed; occupancy is unchanged.
//   outstanding_o counts granted requests that have no response yet, including the one in the slot.
//  Response: m_rsp_valid_i at edge N -> rsp_valid_o[head] = 1 and rsp_data_o = m_rsp_data_i
//   in cycle N+1 (registered). Otherwise rsp_valid_o = 0 and rsp_data_o holds its value.
//  m_rsp_valid_i with tracker empty: dropped, no rsp_valid_o, rsp_err_o set until reset.
//  Full: outstanding_o == MAX_OUTSTANDING with no pop -> no grants; all req_ready_o = 0.
//  Writes also occupy a tracker entry; downstream returns an ack response for each write.
//  Reset mid-operation: slot and tracker are cleared and in-flight responses are lost.
//   The requesters are reset in the same reset domain.
// TESTING
//  1 Single read: req 3 valid, addr 0x100 -> ready_o[3] in cycle 0; m_req addr 0x100, src 3 in
//    cycle 1; m_rsp data 0xDEAD -> rsp_valid_o[3] and data 0xDEAD one cycle later.
//  2 Fairness: all 8 reqs held valid, m_req_ready_i = 1, NUM_CORES = 4 -> grant order
//    0,1,...,7,0; one grant per cycle; no bubbles.
//  3 Backpressure: m_req_ready_i = 0 for 5 cycles -> slot addr/src stable; req_ready_o = 0;
//    no grant is lost when ready rises.
//  4 Full tracker: 4 issued, no responses -> outstanding_o = 4 and no grants. A response plus a
//    pending req in the same cycle -> grant occurs and outstanding_o stays 4.
//  5 Ordering: issue from srcs 5,2,7 -> three responses assert rsp_valid_o[5], [2], [7] in order.
//  6 Errors: response with tracker empty -> rsp_err_o = 1, no rsp_valid_o. Reset asserted with
//    2 outstanding -> all outputs 0, outstanding_o = 0, RR pointer = 0.

Source files
------------

// File: rtl/l1_miss_arbiter.sv
// rtl/l1_miss_arbiter.sv - round-robin L1 miss arbiter with one output slot and source tracker
module l1_miss_arbiter #(
    parameter int NUM_CORES       = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int NUM_REQ        = 2 * NUM_CORES,
    localparam int SRC_W          = $clog2(NUM_REQ),
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]          req_write_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        m_req_valid_o,
    input  logic                        m_req_ready_i,
    output logic [ADDR_W-1:0]           m_req_addr_o,
    output logic                        m_req_write_o,
    output logic [DATA_W-1:0]           m_req_wdata_o,
    output logic [SRC_W-1:0]            m_req_src_o,
    input  logic                        m_rsp_valid_i,
    input  logic [DATA_W-1:0]           m_rsp_data_i,
    output logic [CNT_W-1:0]            outstanding_o,
    output logic                        rsp_err_o
);

    localparam int                 PTR_W     = $clog2(MAX_OUTSTANDING);
    localparam logic [SRC_W:0]     NUM_REQ_E = (SRC_W + 1)'(NUM_REQ);
    localparam logic [SRC_W-1:0]   LAST_REQ  = SRC_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] trk_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] trk_wr_ptr;
    logic [PTR_W-1:0] trk_rd_ptr;
    logic             load;
    logic             any_valid;
    logic             grant;
    logic             pop;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W:0]   cand;

    // A pop in the same cycle frees the entry the new grant needs, so full + response still loads.
    assign load  = (!m_req_valid_o || m_req_ready_i) && ((outstanding_o < MAX_CNT) || m_rsp_valid_i);
    assign pop   = m_rsp_valid_i && (outstanding_o != '0);
    assign grant = load && any_valid;

    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (SRC_W + 1)'(i);
            if (cand >= NUM_REQ_E) begin
                cand = cand - NUM_REQ_E;
            end
            if (!any_valid && req_valid_i[cand[SRC_W-1:0]]) begin
                any_valid = 1'b1;
                grant_idx = cand[SRC_W-1:0];
            end
        end
    end

    assign req_ready_o = grant ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr        <= '0;
            m_req_valid_o <= 1'b0;
            m_req_addr_o  <= '0;
            m_req_write_o <= 1'b0;
            m_req_wdata_o <= '0;
            m_req_src_o   <= '0;
        end else if (grant) begin
            m_req_valid_o <= 1'b1;
            m_req_addr_o  <= req_addr_i[int'(grant_idx) * ADDR_W +: ADDR_W];
            m_req_write_o <= req_write_i[grant_idx];
            m_req_wdata_o <= req_wdata_i[int'(grant_idx) * DATA_W +: DATA_W];
            m_req_src_o   <= grant_idx;
            rr_ptr        <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
        end else if (m_req_ready_i) begin
            m_req_valid_o <= 1'b0;
        end
    end

    // Tracker storage carries no reset; only pointers and occupancy define its contents.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            trk_mem[trk_wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk_wr_ptr    <= '0;
            trk_rd_ptr    <= '0;
            outstanding_o <= '0;
            rsp_valid_o   <= '0;
            rsp_data_o    <= '0;
            rsp_err_o     <= 1'b0;
        end else begin
            if (grant) begin
                trk_wr_ptr <= trk_wr_ptr + 1'b1;
            end
            if (pop) begin
                trk_rd_ptr <= trk_rd_ptr + 1'b1;
            end
            case ({grant, pop})
                2'b10:   outstanding_o <= outstanding_o + 1'b1;
                2'b01:   outstanding_o <= outstanding_o - 1'b1;
                default: outstanding_o <= outstanding_o;
            endcase
            rsp_valid_o <= '0;
            if (pop) begin
                rsp_valid_o <= NUM_REQ'(1) << trk_mem[trk_rd_ptr];
                rsp_data_o  <= m_rsp_data_i;
            end
            if (m_rsp_valid_i && (outstanding_o == '0)) begin
                rsp_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l1_miss_arbiter.sv
// tb/tb_l1_miss_arbiter.sv - scoreboard bench for l1_miss_arbiter
module tb_l1_miss_arbiter;

    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    req_valid_i;
    logic [7:0]    req_ready_o;
    logic [255:0]  req_addr_i;
    logic [7:0]    req_write_i;
    logic [255:0]  req_wdata_i;
    logic [7:0]    rsp_valid_o;
    logic [31:0]   rsp_data_o;
    logic          m_req_valid_o;
    logic          m_req_ready_i;
    logic [31:0]   m_req_addr_o;
    logic          m_req_write_o;
    logic [31:0]   m_req_wdata_o;
    logic [2:0]    m_req_src_o;
    logic          m_rsp_valid_i;
    logic [31:0]   m_rsp_data_i;
    logic [2:0]    outstanding_o;
    logic          rsp_err_o;

    int tests = 0;
    int failed = 0;

    l1_miss_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .m_req_valid_o(m_req_valid_o), .m_req_ready_i(m_req_ready_i),
        .m_req_addr_o(m_req_addr_o), .m_req_write_o(m_req_write_o),
        .m_req_wdata_o(m_req_wdata_o), .m_req_src_o(m_req_src_o),
        .m_rsp_valid_i(m_rsp_valid_i), .m_rsp_data_i(m_rsp_data_i),
        .outstanding_o(outstanding_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk = ~clk;

    typedef struct { int src; logic [31:0] addr; logic wr; logic [31:0] wdata; } req_t;
    typedef struct { int src; logic [31:0] data; } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   src_q[$];
    bit   mv = 0;
    bit   merr = 0;
    bit   rsp_due = 0;
    int   mrr = 0;

    function automatic int exp_grant();
        if (!((!mv || m_req_ready_i) && (src_q.size() < 4 || m_rsp_valid_i))) return -1;
        for (int i = 0; i < NR; i++) begin
            int idx;
            idx = (mrr + i) % NR;
            if (req_valid_i[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference model: advances on each edge from bench-driven inputs only.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv = 0; mrr = 0; merr = 0; rsp_due = 0;
            src_q.delete(); req_q.delete(); rsp_q.delete();
        end else begin
            int g;
            req_t r;
            rsp_t p;
            g = exp_grant();
            rsp_due = 0;
            if (m_rsp_valid_i) begin
                if (src_q.size() != 0) begin
                    p.src = src_q.pop_front();
                    p.data = m_rsp_data_i;
                    rsp_q.push_back(p);
                    rsp_due = 1;
                end else begin
                    merr = 1;
                end
            end
            if (g >= 0) begin
                r.src = g;
                r.addr = req_addr_i[g*32 +: 32];
                r.wr = req_write_i[g];
                r.wdata = req_wdata_i[g*32 +: 32];
                req_q.push_back(r);
                src_q.push_back(g);
                mrr = (g + 1) % NR;
                mv = 1;
            end else if (m_req_ready_i) begin
                mv = 0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [7:0] exp_oh;
        logic [7:0] one;
        req_t e;
        rsp_t p;
        one = 8'h01;
        g = exp_grant();
        exp_oh = (g >= 0) ? (one << g) : 8'h00;
        tests++; if (req_ready_o !== exp_oh) begin failed++; $display("FAIL mon_ready: got %h want %h at %0t", req_ready_o, exp_oh, $time); end
        tests++; if (m_req_valid_o !== mv) begin failed++; $display("FAIL mon_mvalid: got %b want %b at %0t", m_req_valid_o, mv, $time); end
        tests++; if (outstanding_o !== 3'(src_q.size())) begin failed++; $display("FAIL mon_outstanding: got %0d want %0d at %0t", outstanding_o, src_q.size(), $time); end
        tests++; if (rsp_err_o !== merr) begin failed++; $display("FAIL mon_err: got %b want %b at %0t", rsp_err_o, merr, $time); end
        if (rsp_due || rsp_valid_o !== 8'h00) begin
            tests++;
            if (rsp_q.size() == 0) begin
                failed++; $display("FAIL mon_rsp_unexpected: got %h want none at %0t", rsp_valid_o, $time);
            end else begin
                p = rsp_q.pop_front();
                if (rsp_valid_o !== (one << p.src) || rsp_data_o !== p.data) begin
                    failed++; $display("FAIL mon_rsp: got %h/%h want %h/%h at %0t", rsp_valid_o, rsp_data_o, one << p.src, p.data, $time);
                end
            end
        end
        if (rst_n && m_req_valid_o === 1'b1 && m_req_ready_i === 1'b1) begin
            tests++;
            if (req_q.size() == 0) begin
                failed++; $display("FAIL mon_req_unexpected: got src %0d want none at %0t", m_req_src_o, $time);
            end else begin
                e = req_q.pop_front();
                if (m_req_src_o !== 3'(e.src) || m_req_addr_o !== e.addr || m_req_write_o !== e.wr || m_req_wdata_o !== e.wdata) begin
                    failed++; $display("FAIL mon_req: got %0d/%h/%b/%h want %0d/%h/%b/%h at %0t", m_req_src_o, m_req_addr_o, m_req_write_o, m_req_wdata_o, e.src, e.addr, e.wr, e.wdata, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid_i = '0; req_addr_i = '0; req_write_i = '0; req_wdata_i = '0;
        m_req_ready_i = 1'b0; m_rsp_valid_i = 1'b0; m_rsp_data_i = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick(); tick();
        tests++; if (req_ready_o !== 8'h00) begin failed++; $display("FAIL reset_ready: got %h want 00", req_ready_o); end
        tests++; if (m_req_valid_o !== 1'b0) begin failed++; $display("FAIL reset_mvalid: got %b want 0", m_req_valid_o); end
        tests++; if (m_req_addr_o !== 32'h0 || m_req_src_o !== 3'd0) begin failed++; $display("FAIL reset_slot: got %h/%0d want 0/0", m_req_addr_o, m_req_src_o); end
        tests++; if (outstanding_o !== 3'd0) begin failed++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
        tests++; if (rsp_valid_o !== 8'h00 || rsp_data_o !== 32'h0 || rsp_err_o !== 1'b0) begin failed++; $display("FAIL reset_rsp: got %h/%h/%b want 00/0/0", rsp_valid_o, rsp_data_o, rsp_err_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        m_req_ready_i = 1'b1;
        req_valid_i[3] = 1'b1;
        req_addr_i[3*32 +: 32] = 32'h100;
        #1;
        tests++; if (req_ready_o !== 8'h08) begin failed++; $display("FAIL single_ready: got %h want 08", req_ready_o); end
        tick();
        req_valid_i = '0;
        tests++; if (m_req_valid_o !== 1'b1 || m_req_addr_o !== 32'h100 || m_req_src_o !== 3'd3) begin failed++; $display("FAIL single_slot: got %b/%h/%0d want 1/100/3", m_req_valid_o, m_req_addr_o, m_req_src_o); end
        tick();
        m_rsp_valid_i = 1'b1; m_rsp_data_i = 32'hDEAD;
        tick();
        m_rsp_valid_i = 1'b0;
        tests++; if (rsp_valid_o !== 8'h08 || rsp_data_o !== 32'hDEAD) begin failed++; $display("FAIL single_rsp: got %h/%h want 08/dead", rsp_valid_o, rsp_data_o); end
        tick();
        tests++; if (rsp_valid_o !== 8'h00 || rsp_data_o !== 32'hDEAD) begin failed++; $display("FAIL single_rsp_hold: got %h/%h want 00/dead", rsp_valid_o, rsp_data_o); end
    endtask

    task automatic test_fairness();
        logic [7:0] one;
        one = 8'h01;
        do_reset();
        m_req_ready_i = 1'b1;
        req_valid_i = 8'hFF;
        for (int r = 0; r < NR; r++) req_addr_i[r*32 +: 32] = 32'h1000 + 32'(r * 4);
        for (int k = 0; k < 9; k++) begin
            m_rsp_valid_i = (k >= 1);
            m_rsp_data_i = 32'h5000 + 32'(k);
            #1;
            tests++; if (req_ready_o !== (one << (k % 8))) begin failed++; $display("FAIL fair_grant%0d: got %h want %h", k, req_ready_o, one << (k % 8)); end
            if (k >= 1) begin
                tests++; if (m_req_valid_o !== 1'b1 || m_req_src_o !== 3'((k - 1) % 8)) begin failed++; $display("FAIL fair_slot%0d: got %b/%0d want 1/%0d", k, m_req_valid_o, m_req_src_o, (k - 1) % 8); end
            end
            tick();
        end
        req_valid_i = '0;
        m_rsp_valid_i = 1'b1; m_rsp_data_i = 32'h5009;
        tick();
        m_rsp_valid_i = 1'b0;
        tick();
        tests++; if (outstanding_o !== 3'd0) begin failed++; $display("FAIL fair_drain: got %0d want 0", outstanding_o); end
        tests++; if (req_q.size() != 0 || rsp_q.size() != 0) begin failed++; $display("FAIL fair_leftover: got %0d/%0d want 0/0", req_q.size(), rsp_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_req_ready_i = 1'b0;
        req_valid_i = 8'h04;
        req_addr_i[2*32 +: 32] = 32'h200;
        #1;
        tests++; if (req_ready_o !== 8'h04) begin failed++; $display("FAIL bp_first: got %h want 04", req_ready_o); end
        tick();
        req_valid_i = 8'h20;
        req_addr_i[5*32 +: 32] = 32'h500;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (req_ready_o !== 8'h00) begin failed++; $display("FAIL bp_ready%0d: got %h want 00", i, req_ready_o); end
            tests++; if (m_req_valid_o !== 1'b1 || m_req_addr_o !== 32'h200 || m_req_src_o !== 3'd2) begin failed++; $display("FAIL bp_stable%0d: got %b/%h/%0d want 1/200/2", i, m_req_valid_o, m_req_addr_o, m_req_src_o); end
            tick();
        end
        m_req_ready_i = 1'b1;
        #1;
        tests++; if (req_ready_o !== 8'h20) begin failed++; $display("FAIL bp_release: got %h want 20", req_ready_o); end
        tick();
        req_valid_i = '0;
        tests++; if (m_req_addr_o !== 32'h500 || m_req_src_o !== 3'd5) begin failed++; $display("FAIL bp_next: got %h/%0d want 500/5", m_req_addr_o, m_req_src_o); end
        tick();
        m_rsp_valid_i = 1'b1; m_rsp_data_i = 32'hB0;
        tick();
        m_rsp_data_i = 32'hB1;
        tick();
        m_rsp_valid_i = 1'b0;
        tick();
        tests++; if (outstanding_o !== 3'd0) begin failed++; $display("FAIL bp_drain: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_full();
        logic [7:0] one;
        one = 8'h01;
        do_reset();
        m_req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid_i = one << k;
            req_addr_i[k*32 +: 32] = 32'h40 + 32'(k);
            tick();
        end
        req_valid_i = 8'h40;
        req_addr_i[6*32 +: 32] = 32'h600;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (req_ready_o !== 8'h00) begin failed++; $display("FAIL full_blocked%0d: got %h want 00", i, req_ready_o); end
            tests++; if (outstanding_o !== 3'd4) begin failed++; $display("FAIL full_count%0d: got %0d want 4", i, outstanding_o); end
            tick();
        end
        m_rsp_valid_i = 1'b1; m_rsp_data_i = 32'hC0;
        #1;
        tests++; if (req_ready_o !== 8'h40) begin failed++; $display("FAIL full_pushpop: got %h want 40", req_ready_o); end
        tick();
        m_rsp_valid_i = 1'b0;
        req_valid_i = '0;
        tests++; if (outstanding_o !== 3'd4) begin failed++; $display("FAIL full_steady: got %0d want 4", outstanding_o); end
        for (int i = 0; i < 4; i++) begin
            m_rsp_valid_i = 1'b1; m_rsp_data_i = 32'hC1 + 32'(i);
            tick();
        end
        m_rsp_valid_i = 1'b0;
        tick();
        tests++; if (outstanding_o !== 3'd0) begin failed++; $display("FAIL full_drain: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_ordering();
        do_reset();
        m_req_ready_i = 1'b1;
        req_valid_i = 8'h20; req_addr_i[5*32 +: 32] = 32'h50;
        #1;
        tests++; if (req_ready_o !== 8'h20) begin failed++; $display("FAIL ord_g5: got %h want 20", req_ready_o); end
        tick();
        req_valid_i = 8'h04; req_addr_i[2*32 +: 32] = 32'h20;
        req_write_i = 8'h04; req_wdata_i[2*32 +: 32] = 32'h22;
        #1;
        tests++; if (req_ready_o !== 8'h04) begin failed++; $display("FAIL ord_g2: got %h want 04", req_ready_o); end
        tick();
        req_valid_i = 8'h80; req_addr_i[7*32 +: 32] = 32'h70; req_write_i = '0;
        #1;
        tests++; if (req_ready_o !== 8'h80) begin failed++; $display("FAIL ord_g7: got %h want 80", req_ready_o); end
        tick();
        req_valid_i = '0;
        m_rsp_valid_i = 1'b1; m_rsp_data_i = 32'hA5;
        tick();
        tests++; if (rsp_valid_o !== 8'h20 || rsp_data_o !== 32'hA5) begin failed++; $display("FAIL ord_r5: got %h/%h want 20/a5", rsp_valid_o, rsp_data_o); end
        m_rsp_data_i = 32'hA2;
        tick();
        tests++; if (rsp_valid_o !== 8'h04 || rsp_data_o !== 32'hA2) begin failed++; $display("FAIL ord_r2: got %h/%h want 04/a2", rsp_valid_o, rsp_data_o); end
        m_rsp_data_i = 32'hA7;
        tick();
        m_rsp_valid_i = 1'b0;
        tests++; if (rsp_valid_o !== 8'h80 || rsp_data_o !== 32'hA7) begin failed++; $display("FAIL ord_r7: got %h/%h want 80/a7", rsp_valid_o, rsp_data_o); end
        tick();
        tests++; if (req_q.size() != 0 || rsp_q.size() != 0) begin failed++; $display("FAIL ord_leftover: got %0d/%0d want 0/0", req_q.size(), rsp_q.size()); end
    endtask

    task automatic test_errors();
        do_reset();
        m_rsp_valid_i = 1'b1; m_rsp_data_i = 32'hEE;
        tick();
        m_rsp_valid_i = 1'b0;
        tests++; if (rsp_valid_o !== 8'h00 || rsp_err_o !== 1'b1) begin failed++; $display("FAIL err_set: got %h/%b want 00/1", rsp_valid_o, rsp_err_o); end
        tick(); tick();
        tests++; if (rsp_err_o !== 1'b1) begin failed++; $display("FAIL err_sticky: got %b want 1", rsp_err_o); end
        m_req_ready_i = 1'b1;
        req_valid_i = 8'h03;
        req_addr_i[0 +: 32] = 32'h1111; req_addr_i[32 +: 32] = 32'h2222;
        tick(); tick();
        req_valid_i = '0;
        tests++; if (outstanding_o !== 3'd2 || m_req_valid_o !== 1'b1) begin failed++; $display("FAIL err_pre: got %0d/%b want 2/1", outstanding_o, m_req_valid_o); end
        rst_n = 1'b0;
        #1;
        tests++; if (m_req_valid_o !== 1'b0 || m_req_addr_o !== 32'h0 || m_req_src_o !== 3'd0) begin failed++; $display("FAIL err_rst_slot: got %b/%h/%0d want 0/0/0", m_req_valid_o, m_req_addr_o, m_req_src_o); end
        tests++; if (outstanding_o !== 3'd0 || rsp_err_o !== 1'b0 || rsp_valid_o !== 8'h00 || rsp_data_o !== 32'h0) begin failed++; $display("FAIL err_rst_state: got %0d/%b/%h/%h want 0/0/00/0", outstanding_o, rsp_err_o, rsp_valid_o, rsp_data_o); end
        tests++; if (req_ready_o !== 8'h00) begin failed++; $display("FAIL err_rst_ready: got %h want 00", req_ready_o); end
        tick();
        rst_n = 1'b1;
        req_valid_i = 8'hFF;
        #1;
        tests++; if (req_ready_o !== 8'h01) begin failed++; $display("FAIL err_rr_reset: got %h want 01", req_ready_o); end
        tick();
        req_valid_i = '0;
        m_rsp_valid_i = 1'b1; m_rsp_data_i = 32'h77;
        tick();
        m_rsp_valid_i = 1'b0;
        tick();
        tests++; if (outstanding_o !== 3'd0 || rsp_err_o !== 1'b0) begin failed++; $display("FAIL err_final: got %0d/%b want 0/0", outstanding_o, rsp_err_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_full();
        test_ordering();
        test_errors();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
